fuzzificador_it2_seq: RTL

// Parametrised, time-multiplexed interval type-2 trapezoidal fuzzifier; successor to the fixed 2x3 fuzzifier.

---
 rtl/fuzzificador_it2_seq.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/fuzzificador_it2_seq.sv
// rtl/fuzzificador_it2_seq.sv - time-multiplexed interval type-2 trapezoidal fuzzifier
// One shared restoring divider evaluates every UP/LOW trapezoid in turn.
module fuzzificador_it2_seq #(
   parameter  int W    = 8,
   parameter  int N_IN = 2,
   parameter  int N_MF = 3,
   localparam int K    = N_IN * N_MF,
   localparam int AW   = $clog2(K * 8)
) (
   input  logic              clk,
   input  logic              RESET,
   input  logic              EN_SCLK,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [N_IN*W-1:0] in_data,
   input  logic              cfg_we,
   input  logic [AW-1:0]     cfg_addr,
   input  logic [W-1:0]      cfg_data,
   output logic              cfg_err,
   output logic [K*W-1:0]    mu_up,
   output logic [K*W-1:0]    mu_low,
   output logic [K-1:0]      active,
   output logic              busy,
   output logic              done
);
   localparam int             EW      = AW - 2;
   localparam int             CW      = $clog2(W);
   localparam logic [W-1:0]   MAXV    = '1;
   localparam logic [EW-1:0]  EV_LAST = EW'(2 * K - 1);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DIV, S_WRITE, S_PUB} state_t;
   state_t state;

   logic [W-1:0]      pts    [K*8];
   logic [W-1:0]      sh_up  [K];
   logic [W-1:0]      sh_low [K];
   logic [N_IN*W-1:0] x_reg;
   logic [EW-1:0]     ev;
   logic [CW-1:0]     dcnt;
   logic [W-1:0]      rem, qsh, dvs;

   logic [W-1:0]      x, pa, pb, pc, pd, diff, dv;
   logic [2*W-1:0]    num;
   logic [W:0]        trial, sub;

   assign in_ready = (state == S_IDLE);
   assign busy     = (state != S_IDLE);

   // ev = {k, ul}, so the point table address is simply {ev, pt}
   always_comb begin
      x = '0;
      for (int i = 0; i < N_IN; i++)
         if (int'(ev[EW-1:1]) / N_MF == i) x = x_reg[i*W +: W];
      pa   = pts[{ev, 2'd0}];
      pb   = pts[{ev, 2'd1}];
      pc   = pts[{ev, 2'd2}];
      pd   = pts[{ev, 2'd3}];
      diff = '0;
      dv   = W'(1);
      num  = '0;
      if (x >= pb && x <= pc) begin
         num = {{W{1'b0}}, MAXV};
      end else if (x <= pa || x >= pd) begin
         num = '0;
      end else if (x < pb) begin
         diff = x - pa;
         dv   = pb - pa;
         num  = {diff, {W{1'b0}}} - {{W{1'b0}}, diff};
      end else begin
         diff = pd - x;
         dv   = pd - pc;
         num  = {diff, {W{1'b0}}} - {{W{1'b0}}, diff};
      end
      trial = {rem, qsh[W-1]};
      sub   = trial - {1'b0, dvs};
   end

   always_ff @(posedge clk or negedge RESET) begin
      if (!RESET) begin
         state   <= S_IDLE;
         x_reg   <= '0;
         ev      <= '0;
         dcnt    <= '0;
         rem     <= '0;
         qsh     <= '0;
         dvs     <= '0;
         mu_up   <= '0;
         mu_low  <= '0;
         active  <= '0;
         done    <= 1'b0;
         cfg_err <= 1'b0;
         for (int a = 0; a < K * 8; a++) pts[a] <= '0;
         for (int k = 0; k < K; k++) begin
            sh_up[k]  <= '0;
            sh_low[k] <= '0;
         end
      end else if (EN_SCLK) begin
         done    <= 1'b0;
         cfg_err <= 1'b0;
         if (cfg_we) begin
            if (state == S_IDLE && int'(cfg_addr) < K * 8) pts[cfg_addr] <= cfg_data;
            else cfg_err <= 1'b1;
         end
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  x_reg <= in_data;
                  ev    <= '0;
                  state <= S_LOAD;
               end
            end
            S_LOAD: begin
               rem   <= num[2*W-1:W];
               qsh   <= num[W-1:0];
               dvs   <= dv;
               dcnt  <= '0;
               state <= S_DIV;
            end
            S_DIV: begin
               // sub[W] set means the trial remainder is below the divisor
               rem  <= sub[W] ? trial[W-1:0] : sub[W-1:0];
               qsh  <= {qsh[W-2:0], ~sub[W]};
               dcnt <= dcnt + 1'b1;
               if (dcnt == CW'(W - 1)) state <= S_WRITE;
            end
            S_WRITE: begin
               if (ev[0]) sh_low[ev[EW-1:1]] <= qsh;
               else       sh_up[ev[EW-1:1]]  <= qsh;
               if (ev == EV_LAST) begin
                  state <= S_PUB;
               end else begin
                  ev    <= ev + 1'b1;
                  state <= S_LOAD;
               end
            end
            S_PUB: begin
               for (int k = 0; k < K; k++) begin
                  mu_up[k*W +: W]  <= sh_up[k];
                  mu_low[k*W +: W] <= sh_low[k];
                  active[k]        <= (sh_up[k] != '0);
               end
               done  <= 1'b1;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule
